// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the movement scheduler and the falling-piece datapath.
// Holds the movement command codes and the arbiter state encoding.
package move_scheduler_pkg;

   localparam int unsigned MV_W = 4;

   localparam logic [MV_W-1:0] MV_CW    = 4'd0;
   localparam logic [MV_W-1:0] MV_ACW   = 4'd1;
   localparam logic [MV_W-1:0] MV_DOWN  = 4'd2;
   localparam logic [MV_W-1:0] MV_LEFT  = 4'd3;
   localparam logic [MV_W-1:0] MV_RIGHT = 4'd4;
   localparam logic [MV_W-1:0] MV_NONE  = 4'd5;

   localparam int unsigned N_USER = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

endpackage

// File: rtl/move_scheduler_gravity_timer.sv
// Gravity timer: counts ce-cycles up to a velocity-shifted limit and flags expiry.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   ce              clock enable
//   clear           synchronous clear (game over)
//   drop            granted soft drop; restarts the period
//   velocity        speed select; period = GRAV_BASE >> velocity
//   tick            registered one-ce-cycle expiry pulse
//   expire_c        combinational expiry, valid on the cycle the counter wraps
module move_scheduler_gravity_timer #(
   parameter int unsigned GRAV_BASE = 25_000_000,
   parameter int unsigned CNT_W     = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       clear,
   input  logic       drop,
   input  logic [1:0] velocity,
   output logic       tick,
   output logic       expire_c
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] limit_c;

   // Comparing with >= makes a velocity increase that lands below the
   // current count expire on the very next ce-cycle.
   always_comb begin
      limit_c  = CNT_W'((GRAV_BASE >> velocity) - 32'd1);
      expire_c = ce && !clear && !drop && (count >= limit_c);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (ce) begin
         tick <= expire_c;
         if (clear || drop || expire_c) begin
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/move_scheduler.sv
// Movement scheduler: edge-detects the debounced buttons, holds each request
// pending together with gravity, and issues one movement command at a time
// over a valid/ready handshake.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   ce                    clock enable; all state advances only when high
//   clockwise_db .. right_db  debounced button levels
//   velocity              gravity speed select
//   game_over             clears all pending work and blocks new requests
//   move_ready            datapath accepts the current command
//   movement              command code (MV_* in the package)
//   move_valid            movement carries a live command
//   grav_tick             one-ce-cycle pulse on gravity expiry
module move_scheduler #(
   parameter int unsigned GRAV_BASE  = 25_000_000,
   parameter int unsigned CNT_W      = 25,
   parameter int unsigned STARVE_MAX = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       clockwise_db,
   input  logic       anti_clkwise_db,
   input  logic       down_db,
   input  logic       left_db,
   input  logic       right_db,
   input  logic [1:0] velocity,
   input  logic       game_over,
   input  logic       move_ready,
   output logic [3:0] movement,
   output logic       move_valid,
   output logic       grav_tick
);

   import move_scheduler_pkg::*;

   localparam int unsigned ST_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   state_t            state;
   logic [N_USER-1:0] btn_c;
   logic [N_USER-1:0] btn_q;
   logic [N_USER-1:0] edge_c;
   logic [N_USER-1:0] pend;
   logic [N_USER-1:0] user_clr_c;
   logic              grav_pend;
   logic              grav_clr_c;
   logic [ST_W-1:0]   starve;
   logic              starved_c;
   logic              grant_c;
   logic              drop_c;
   logic              expire_c;
   logic [MV_W-1:0]   sel_c;

   // Bit index equals the movement code of each button.
   assign btn_c = {right_db, left_db, down_db, anti_clkwise_db, clockwise_db};

   // Rising edges only; game_over masks them while the edge registers still sample.
   assign edge_c = btn_c & ~btn_q & {N_USER{~game_over}};

   // Grant happens on the accepting ce-cycle of an issued command.
   assign grant_c   = ce && !game_over && (state == ISSUE) && move_ready;
   assign drop_c    = grant_c && (movement == MV_DOWN);
   assign starved_c = grav_pend && (starve == ST_W'(STARVE_MAX));

   // Per-flag clear strobes decoded from the command being granted.
   always_comb begin
      user_clr_c = '0;
      for (int i = 0; i < int'(N_USER); i++) begin
         user_clr_c[i] = grant_c && (movement == MV_W'(i));
      end
      grav_clr_c = grant_c && (movement == MV_NONE);
   end

   // Winner select: forced gravity when starved, else lowest code wins.
   always_comb begin
      sel_c = MV_NONE;
      if (!starved_c) begin
         for (int i = int'(N_USER) - 1; i >= 0; i--) begin
            if (pend[i]) sel_c = MV_W'(i);
         end
      end
   end

   move_scheduler_gravity_timer #(
      .GRAV_BASE (GRAV_BASE),
      .CNT_W     (CNT_W)
   ) u_gravity_timer (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .clear    (game_over),
      .drop     (drop_c),
      .velocity (velocity),
      .tick     (grav_tick),
      .expire_c (expire_c)
   );

   // Arbiter FSM with pending flags and starvation counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         btn_q      <= '0;
         pend       <= '0;
         grav_pend  <= 1'b0;
         starve     <= '0;
         movement   <= MV_NONE;
         move_valid <= 1'b0;
      end else if (ce) begin
         btn_q <= btn_c;
         if (game_over) begin
            state      <= IDLE;
            pend       <= '0;
            grav_pend  <= 1'b0;
            starve     <= '0;
            movement   <= MV_NONE;
            move_valid <= 1'b0;
         end else begin
            // A new request on the granting cycle keeps its flag set.
            pend      <= (pend & ~user_clr_c) | edge_c;
            grav_pend <= (grav_pend & ~grav_clr_c) | expire_c;
            case (state)
               IDLE: begin
                  if ((|pend) || grav_pend) begin
                     movement   <= sel_c;
                     move_valid <= 1'b1;
                     state      <= ISSUE;
                  end
               end
               ISSUE: begin
                  if (move_ready) begin
                     movement   <= MV_NONE;
                     move_valid <= 1'b0;
                     state      <= IDLE;
                     if (movement == MV_NONE) begin
                        starve <= '0;
                     end else if (grav_pend && (starve != ST_W'(STARVE_MAX))) begin
                        starve <= starve + ST_W'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
